// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: the instruction
// memory request/ack channel and the valid/ready channel toward decode.
// The master modport is the fetch stage's view; slave is the environment's.
interface fetch_stage_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            id_valid;
   logic            id_ready;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc,
      input  imem_ack, imem_rdata, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc,
      output imem_ack, imem_rdata, id_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the riscie pipeline. Owns the PC, issues one
// word fetch at a time to instruction memory and buffers {pc, instr} pairs
// in a small FIFO that feeds decode. A redirect from a later stage flushes
// the buffer and any in-flight fetch.
// Optional feature: define FETCH_STATS_EN to add the fetch_count port, a
// free-running count of instructions handed to decode.
module fetch_stage #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   fetch_stage_if.master   bus
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]     fetch_count
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] target;

   logic [31:0]     instr_mem [FIFO_DEPTH];
   logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_after_push;

   logic            head_valid;
   logic            push;
   logic            pop;

   // A redirect hides the head immediately so decode can never consume a
   // stale instruction in the redirect cycle; the id_* data is zeroed
   // whenever nothing valid is presented.
   assign target           = redirect_pc & ~XLEN'(3);
   assign pc_next          = pc + XLEN'(4);
   assign head_valid       = (count != '0);
   assign bus.id_valid     = head_valid & ~redirect;
   assign bus.id_instr     = bus.id_valid ? instr_mem[rd_ptr] : '0;
   assign bus.id_pc        = bus.id_valid ? pc_mem[rd_ptr] : '0;
   assign pop              = bus.id_valid & bus.id_ready;
   assign push             = (state == FETCH) & bus.imem_ack & ~redirect;
   assign count_after_push = count + CW'(1) - CW'(pop);
   assign bus.imem_req     = (state == FETCH) || (state == FLUSH);
   assign bus.imem_addr    = addr;

   // Fetch control: pc is the next address to fetch, addr is the address on
   // the bus. They only differ in FLUSH, where the old request must be held
   // until memory acknowledges it while pc already points at the target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         pc    <= RESET_PC;
         addr  <= RESET_PC;
      end else if (redirect) begin
         pc <= target;
         case (state)
            FETCH, FLUSH: begin
               if (bus.imem_ack) begin
                  state <= FETCH;
                  addr  <= target;
               end else begin
                  state <= FLUSH;
               end
            end
            default: begin
               state <= FETCH;
               addr  <= target;
            end
         endcase
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
               addr  <= pc;
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  pc   <= pc_next;
                  addr <= pc_next;
                  if (count_after_push < CW'(FIFO_DEPTH)) begin
                     state <= FETCH;
                  end else begin
                     state <= FULL;
                  end
               end
            end
            FULL: begin
               if (pop) begin
                  state <= FETCH;
               end
            end
            FLUSH: begin
               if (bus.imem_ack) begin
                  state <= FETCH;
                  addr  <= pc;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // FIFO bookkeeping: a redirect empties the buffer outright; otherwise
   // push and pop may happen together, leaving the occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; entries are only read when counted as valid, so the
   // array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= bus.imem_rdata;
         pc_mem[wr_ptr]    <= pc;
      end
   end

`ifdef FETCH_STATS_EN
   // Count instructions handed to decode; only reset clears it, redirects do not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= '0;
      end else if (pop) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. A second instance with
// RESET_PC = 0xFFFFFFF8 runs alongside to exercise PC wrap-around.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   int          checks;
   int          fails;

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] fetch_count_wrap;
`endif

   fetch_stage_if #(.XLEN(32)) bus ();
   fetch_stage_if #(.XLEN(32)) bus_wrap ();

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus.master)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
      .clk         (clk),
      .rst         (rst),
      .redirect    (1'b0),
      .redirect_pc (32'h0),
      .bus         (bus_wrap.master)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count (fetch_count_wrap)
`endif
   );

   // Memory model: instruction word is a fixed scramble of its address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign bus.imem_rdata      = instr_of(bus.imem_addr);
   assign bus_wrap.imem_rdata = instr_of(bus_wrap.imem_addr);
   assign bus_wrap.imem_ack   = 1'b1;
   assign bus_wrap.id_ready   = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.imem_ack    = 1'b0;
      bus.id_ready    = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = 32'h0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   initial begin
      checks       = 0;
      fails        = 0;
      rst          = 1'b1;
      redirect     = 1'b0;
      redirect_pc  = 32'h0;
      bus.imem_ack = 1'b0;
      bus.id_ready = 1'b0;
      #2;

      // Reset values
      check("rst_req",   {63'd0, bus.imem_req}, 64'd0);
      check("rst_addr",  {32'd0, bus.imem_addr}, 64'd0);
      check("rst_valid", {63'd0, bus.id_valid}, 64'd0);
      check("rst_instr", {32'd0, bus.id_instr}, 64'd0);
      check("rst_pc",    {32'd0, bus.id_pc}, 64'd0);
      check("rst_wrap_addr", {32'd0, bus_wrap.imem_addr}, 64'hFFFF_FFF8);
`ifdef FETCH_STATS_EN
      check("rst_count", {32'd0, fetch_count}, 64'd0);
`endif

      // Streaming: ack tied high, decode always ready
      do_reset();
      bus.imem_ack = 1'b1;
      bus.id_ready = 1'b1;
      check("idle_no_req", {63'd0, bus.imem_req}, 64'd0);
      tick();
      check("t1_first_req",  {63'd0, bus.imem_req}, 64'd1);
      check("t1_first_addr", {32'd0, bus.imem_addr}, 64'd0);
      check("t1_no_valid",   {63'd0, bus.id_valid}, 64'd0);
      check("t5_wrap_a0", {32'd0, bus_wrap.imem_addr}, 64'hFFFF_FFF8);
      tick();
      check("t1_valid0", {63'd0, bus.id_valid}, 64'd1);
      check("t1_pc0",    {32'd0, bus.id_pc}, 64'd0);
      check("t1_instr0", {32'd0, bus.id_instr}, {32'd0, instr_of(32'd0)});
      check("t1_addr4",  {32'd0, bus.imem_addr}, 64'd4);
      check("t5_wrap_a1", {32'd0, bus_wrap.imem_addr}, 64'hFFFF_FFFC);
      tick();
      check("t5_wrap_a2",  {32'd0, bus_wrap.imem_addr}, 64'h0);
      check("t5_wrap_pc",  {32'd0, bus_wrap.id_pc}, 64'hFFFF_FFFC);
      for (int k = 1; k <= 3; k++) begin
         check("t1_stream_pc",   {32'd0, bus.id_pc}, 64'(4 * k));
         check("t1_stream_addr", {32'd0, bus.imem_addr}, 64'(4 * (k + 1)));
         check("t1_stream_valid", {63'd0, bus.id_valid}, 64'd1);
         tick();
      end
`ifdef FETCH_STATS_EN
      // Pops happened at the edges delivering pcs 0,4,8,12 -> next check after one more
      check("t6_count4", {32'd0, fetch_count}, 64'd4);
      tick();
      check("t6_count5", {32'd0, fetch_count}, 64'd5);
`endif
      // Asynchronous reset mid-FETCH, away from any clock edge
      #1;
      rst = 1'b1;
      #1;
      check("t6_async_req",   {63'd0, bus.imem_req}, 64'd0);
      check("t6_async_valid", {63'd0, bus.id_valid}, 64'd0);
      check("t6_async_addr",  {32'd0, bus.imem_addr}, 64'd0);
`ifdef FETCH_STATS_EN
      check("t6_count_clr", {32'd0, fetch_count}, 64'd0);
`endif

      // Back-pressure: decode stalls, FIFO fills after two pushes
      do_reset();
      bus.imem_ack = 1'b1;
      tick();
      tick();
      tick();
      check("t2_full_req",   {63'd0, bus.imem_req}, 64'd0);
      check("t2_full_head",  {32'd0, bus.id_pc}, 64'd0);
      tick();
      check("t2_still_full", {63'd0, bus.imem_req}, 64'd0);
      bus.id_ready = 1'b1;
      #1;
      check("t2_pop_valid", {63'd0, bus.id_valid}, 64'd1);
      check("t2_pop_pc",    {32'd0, bus.id_pc}, 64'd0);
      tick();
      bus.id_ready = 1'b0;
      check("t2_rereq",      {63'd0, bus.imem_req}, 64'd1);
      check("t2_rereq_addr", {32'd0, bus.imem_addr}, 64'd8);
      check("t2_next_head",  {32'd0, bus.id_pc}, 64'd4);
      tick();
      check("t2_full_again", {63'd0, bus.imem_req}, 64'd0);

      // Redirect while a request waits for a late ack
      do_reset();
      bus.id_ready = 1'b1;
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      check("t3_r_valid", {63'd0, bus.id_valid}, 64'd0);
      tick();
      redirect = 1'b0;
      check("t3_hold_req",  {63'd0, bus.imem_req}, 64'd1);
      check("t3_hold_addr", {32'd0, bus.imem_addr}, 64'd0);
      tick();
      check("t3_hold_addr2", {32'd0, bus.imem_addr}, 64'd0);
      bus.imem_ack = 1'b1;
      tick();
      check("t3_new_addr", {32'd0, bus.imem_addr}, 64'h100);
      check("t3_discard",  {63'd0, bus.id_valid}, 64'd0);
      tick();
      check("t3_first_valid", {63'd0, bus.id_valid}, 64'd1);
      check("t3_first_pc",    {32'd0, bus.id_pc}, 64'h100);
      check("t3_first_instr", {32'd0, bus.id_instr}, {32'd0, instr_of(32'h100)});

      // Redirect with two entries buffered, then redirect coincident with an ack
      do_reset();
      bus.imem_ack = 1'b1;
      tick();
      tick();
      tick();
      check("t4_full", {63'd0, bus.imem_req}, 64'd0);
      redirect     = 1'b1;
      redirect_pc  = 32'h0000_0200;
      bus.id_ready = 1'b1;
      #1;
      check("t4_r_valid", {63'd0, bus.id_valid}, 64'd0);
      check("t4_r_pc",    {32'd0, bus.id_pc}, 64'd0);
      tick();
      redirect = 1'b0;
      check("t4_empty", {63'd0, bus.id_valid}, 64'd0);
      check("t4_addr",  {32'd0, bus.imem_addr}, 64'h200);
      check("t4_req",   {63'd0, bus.imem_req}, 64'd1);
      tick();
      check("t4_head_pc", {32'd0, bus.id_pc}, 64'h200);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0302;
      #1;
      check("t4_ack_r_valid", {63'd0, bus.id_valid}, 64'd0);
      tick();
      redirect = 1'b0;
      check("t4_ack_empty", {63'd0, bus.id_valid}, 64'd0);
      check("t4_ack_addr",  {32'd0, bus.imem_addr}, 64'h300);
      tick();
      check("t4_ack_head", {32'd0, bus.id_pc}, 64'h300);

      $display("[TB] %0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
